msrv32_wb_stage_unit: RTL and testbench
=======================================

Name: msrv32_wb_stage_unit

Overview:
Parametrised, registered write-back stage for the msrv32 core. It replaces the purely combinational write-back mux with the following:
- an N-source packed mux;
- a valid/ready handshake toward the execute side;
- a load-wait state machine that holds a load until the load unit returns data;
- a registered register-file write port;
- a retire counter.

It sits between the execute/load units and the integer register file. It also keeps the ALU second-operand select mux.

Parameters:
XLEN, 32, datapath width.
NUM_SRC, 8, number of write-back sources on src_bus_in (2..2^SEL_W).
SEL_W, 3, width of wb_mux_sel_in.
LU_SEL, 1, source index that belongs to the load unit and requires lu_valid_in.
MAX_WAIT, 15, maximum WAIT_LD cycles before the load is abandoned (1..255).

Ports:
clk_in  in  1  clock; all state updates on the rising edge.
rst_in  in  1  reset; synchronous, active-high.
valid_in  in  1  an instruction is presented for write-back.
ready_out  out  1  stage can accept; valid_in && ready_out = accept.
wb_mux_sel_in  in  SEL_W  write-back source index.
rd_addr_in  in  5  destination register.
rf_wr_en_in  in  1  instruction writes rd.
src_bus_in  in  NUM_SRC*XLEN  source k at [k*XLEN +: XLEN].
lu_valid_in  in  1  load data on source LU_SEL is valid this cycle.
flush_in  in  1  kill the pending or presented instruction.
alu_src_in  in  1  1 selects rs2_in, 0 selects imm_in.
rs2_in  in  XLEN  rs2 operand.
imm_in  in  XLEN  immediate operand.
alu_2nd_src_mux_out  out  XLEN  combinational ALU operand-2 mux.
wb_valid_out  out  1  one-cycle pulse per retired instruction.
wb_wr_en_out  out  1  register-file write enable.
wb_rd_addr_out  out  5  register-file write address.
wb_data_out  out  XLEN  register-file write data.
load_timeout_out  out  1  one-cycle pulse when a load is abandoned.
retire_cnt_out  out  32  count of wb_valid_out pulses; wraps.

Behaviour:
- Reset (rst_in=1 at an edge): state=IDLE, wait counter=0, and every registered output=0 (wb_valid_out, wb_wr_en_out, wb_rd_addr_out, wb_data_out, load_timeout_out, retire_cnt_out). ready_out=0 while rst_in=1. Reset overrides any in-flight load.
- alu_2nd_src_mux_out = alu_src_in ? rs2_in : imm_in. It is purely combinational and independent of the FSM.
- Source select: sel >= NUM_SRC selects source 0.
- Write-enable rule: wb_wr_en_out = rf_wr_en && (rd != 0) && wb_valid_out. It is never 1 without wb_valid_out.
- FSM state IDLE:
  - ready_out=1.
  - On accept with flush_in=0, and either sel != LU_SEL or lu_valid_in=1: the next cycle sees wb_valid_out=1 with data = src[sel], rd and wr_en registered. Latency is exactly 1 cycle, and back-to-back accepts give one pulse per cycle.
  - On accept with sel == LU_SEL and lu_valid_in=0: latch rd and wr_en, clear the counter, go to WAIT_LD. wb_valid_out=0 next cycle.
  - On accept with flush_in=1: the instruction is dropped and nothing is written.
- FSM state WAIT_LD:
  - ready_out=0; valid_in is ignored.
  - Each cycle, check in priority order:
    1. flush_in=1: go to IDLE, no write.
    2. lu_valid_in=1: next cycle sees wb_valid_out=1 with data = src[LU_SEL] sampled that cycle and the latched rd/wr_en; go to IDLE.
    3. Counter == MAX_WAIT-1: load_timeout_out pulses next cycle, wb_valid_out=0, go to IDLE.
    4. Otherwise: increment the counter.
  - flush_in and lu_valid_in in the same cycle: flush wins.
- Output timing:
  - wb_valid_out and load_timeout_out are single-cycle pulses.
  - wb_data_out and wb_rd_addr_out hold their last values when wb_valid_out=0.
- Retire counter: retire_cnt_out increments by 1 in the cycle wb_valid_out is 1, including rd=0 and wr_en=0 retirements. It wraps from 0xFFFFFFFF to 0.

Test Plan:
1. Reset, then accept sel=0 with src0=0x1234_5678, rd=5, wr_en=1 → next cycle: valid=1, wr_en=1, rd=5, data=0x1234_5678, retire_cnt=1.
2. Accept sel=LU_SEL with lu_valid_in=0, rd=7; assert lu_valid_in 3 cycles later with src1=0xDEAD_BEEF → ready_out=0 for those cycles; one cycle after lu_valid_in: valid=1, rd=7, data=0xDEAD_BEEF.
3. Load with lu_valid_in held 0 → exactly MAX_WAIT=15 wait cycles, then load_timeout_out=1 for one cycle, wb_valid_out never asserted, ready_out=1 again.
4. In WAIT_LD, assert flush_in and lu_valid_in together → no write-back, state IDLE next cycle, retire count unchanged.
5. Accept rd=0, wr_en=1; then sel=7 with NUM_SRC=6 → first retirement has valid=1, wr_en=0; second has data = src0.
6. Assert rst_in mid-WAIT_LD, deassert, then accept sel=2 with imm source 0x0000_0ABC → all outputs 0 during reset; next retirement data=0xABC and retire_cnt=1. Also check alu_src_in toggling switches alu_2nd_src_mux_out between rs2_in and imm_in in the same cycle.

Source files
------------

// File: rtl/msrv32_wb_stage_unit.sv
// Registered msrv32 write-back stage: N-source mux, valid/ready handshake,
// load-wait FSM with timeout, registered register-file write port and retire counter.
module msrv32_wb_stage_unit #(
  parameter int XLEN     = 32,
  parameter int NUM_SRC  = 8,
  parameter int SEL_W    = 3,
  parameter int LU_SEL   = 1,
  parameter int MAX_WAIT = 15
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic [SEL_W-1:0]        wb_mux_sel_in,
  input  logic [4:0]              rd_addr_in,
  input  logic                    rf_wr_en_in,
  input  logic [NUM_SRC*XLEN-1:0] src_bus_in,
  input  logic                    lu_valid_in,
  input  logic                    flush_in,
  input  logic                    alu_src_in,
  input  logic [XLEN-1:0]         rs2_in,
  input  logic [XLEN-1:0]         imm_in,
  output logic [XLEN-1:0]         alu_2nd_src_mux_out,
  output logic                    wb_valid_out,
  output logic                    wb_wr_en_out,
  output logic [4:0]              wb_rd_addr_out,
  output logic [XLEN-1:0]         wb_data_out,
  output logic                    load_timeout_out,
  output logic [31:0]             retire_cnt_out
);

  typedef enum logic {IDLE, WAIT_LD} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t          state;
  logic [7:0]      wait_cnt;
  logic [4:0]      ld_rd;
  logic            ld_wr_en;
  logic [XLEN-1:0] sel_data;
  logic [XLEN-1:0] lu_data;
  logic            is_load;

  assign alu_2nd_src_mux_out = alu_src_in ? rs2_in : imm_in;
  assign ready_out = (state == IDLE) && !rst_in;
  assign is_load   = (wb_mux_sel_in == SEL_W'(LU_SEL));
  assign lu_data   = src_bus_in[LU_SEL*XLEN +: XLEN];

  // Out-of-range selects fall through to source 0.
  always_comb begin
    sel_data = src_bus_in[0 +: XLEN];
    for (int unsigned k = 1; k < NUM_SRC; k++) begin
      if (wb_mux_sel_in == SEL_W'(k)) sel_data = src_bus_in[k*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      ld_rd            <= '0;
      ld_wr_en         <= 1'b0;
      wb_valid_out     <= 1'b0;
      wb_wr_en_out     <= 1'b0;
      wb_rd_addr_out   <= '0;
      wb_data_out      <= '0;
      load_timeout_out <= 1'b0;
      retire_cnt_out   <= '0;
    end else begin
      wb_valid_out     <= 1'b0;
      wb_wr_en_out     <= 1'b0;
      load_timeout_out <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in && !flush_in) begin
            if (is_load && !lu_valid_in) begin
              state    <= WAIT_LD;
              wait_cnt <= '0;
              ld_rd    <= rd_addr_in;
              ld_wr_en <= rf_wr_en_in;
            end else begin
              wb_valid_out   <= 1'b1;
              wb_wr_en_out   <= rf_wr_en_in && (rd_addr_in != 5'd0);
              wb_rd_addr_out <= rd_addr_in;
              wb_data_out    <= sel_data;
              retire_cnt_out <= retire_cnt_out + 32'd1;
            end
          end
        end
        WAIT_LD: begin
          // Flush beats returning load data, which beats the timeout.
          if (flush_in) begin
            state <= IDLE;
          end else if (lu_valid_in) begin
            state          <= IDLE;
            wb_valid_out   <= 1'b1;
            wb_wr_en_out   <= ld_wr_en && (ld_rd != 5'd0);
            wb_rd_addr_out <= ld_rd;
            wb_data_out    <= lu_data;
            retire_cnt_out <= retire_cnt_out + 32'd1;
          end else if (wait_cnt == WAIT_LAST) begin
            state            <= IDLE;
            load_timeout_out <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msrv32_wb_stage_unit.sv
// Self-checking bench for msrv32_wb_stage_unit: vector table, directed load
// sequences and randomized traffic against a behavioural model.
module tb_msrv32_wb_stage_unit;
  localparam int XLEN     = 32;
  localparam int NUM_SRC  = 6;
  localparam int SEL_W    = 3;
  localparam int LU_SEL   = 1;
  localparam int MAX_WAIT = 15;

  logic                    clk = 1'b0;
  logic                    rst, valid, ready, lu_valid, flush, alu_src, wr_en;
  logic [SEL_W-1:0]        sel;
  logic [4:0]              rd;
  logic [NUM_SRC*XLEN-1:0] src_bus;
  logic [XLEN-1:0]         src [NUM_SRC];
  logic [XLEN-1:0]         rs2, imm, alu_out, wb_data;
  logic                    wb_valid, wb_wr, timeout;
  logic [4:0]              wb_rd;
  logic [31:0]             retire_cnt;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign src_bus[g*XLEN +: XLEN] = src[g];
  end

  msrv32_wb_stage_unit #(
    .XLEN(XLEN), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .LU_SEL(LU_SEL), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk_in(clk), .rst_in(rst), .valid_in(valid), .ready_out(ready),
    .wb_mux_sel_in(sel), .rd_addr_in(rd), .rf_wr_en_in(wr_en), .src_bus_in(src_bus),
    .lu_valid_in(lu_valid), .flush_in(flush), .alu_src_in(alu_src), .rs2_in(rs2),
    .imm_in(imm), .alu_2nd_src_mux_out(alu_out), .wb_valid_out(wb_valid),
    .wb_wr_en_out(wb_wr), .wb_rd_addr_out(wb_rd), .wb_data_out(wb_data),
    .load_timeout_out(timeout), .retire_cnt_out(retire_cnt)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a pending load is a flag plus the number of cycles spent waiting.
  bit          m_pending;
  int          m_waited;
  logic [4:0]  m_rd;
  logic        m_wr;
  logic        e_valid, e_wr, e_to;
  logic [4:0]  e_rd;
  logic [31:0] e_data, e_cnt;

  task automatic retire(input logic [31:0] d, input logic [4:0] r, input logic w);
    e_valid = 1'b1;
    e_wr    = w && (r != 5'd0);
    e_rd    = r;
    e_data  = d;
    e_cnt   = e_cnt + 32'd1;
  endtask

  task automatic model_step();
    int s;
    s = (int'(sel) < NUM_SRC) ? int'(sel) : 0;
    e_valid = 1'b0; e_wr = 1'b0; e_to = 1'b0;
    if (rst) begin
      m_pending = 1'b0; m_waited = 0;
      e_rd = '0; e_data = '0; e_cnt = '0;
    end else if (!m_pending) begin
      if (valid && !flush) begin
        if (s == LU_SEL && !lu_valid) begin
          m_pending = 1'b1; m_waited = 0; m_rd = rd; m_wr = wr_en;
        end else begin
          retire(src[s], rd, wr_en);
        end
      end
    end else begin
      m_waited++;
      if (flush) m_pending = 1'b0;
      else if (lu_valid) begin
        retire(src[LU_SEL], m_rd, m_wr);
        m_pending = 1'b0;
      end else if (m_waited == MAX_WAIT) begin
        e_to = 1'b1;
        m_pending = 1'b0;
      end
    end
  endtask

  task automatic tick();
    #1;
    chk("ready", 32'(ready), 32'(!rst && !m_pending));
    chk("alu_mux", alu_out, alu_src ? rs2 : imm);
    model_step();
    @(posedge clk);
    #1;
    chk("wb_valid", 32'(wb_valid), 32'(e_valid));
    chk("wb_wr_en", 32'(wb_wr), 32'(e_wr));
    chk("wb_rd", 32'(wb_rd), 32'(e_rd));
    chk("wb_data", wb_data, e_data);
    chk("timeout", 32'(timeout), 32'(e_to));
    chk("retire_cnt", retire_cnt, e_cnt);
  endtask

  task automatic idle_inputs();
    valid = 1'b0; flush = 1'b0; lu_valid = 1'b0; sel = '0; rd = '0; wr_en = 1'b0;
  endtask

  typedef struct {
    logic [SEL_W-1:0] sel;
    logic [4:0]       rd;
    logic             wr;
    logic             flush;
    logic             x_valid;
    logic             x_wr;
    logic [31:0]      x_data;
  } vec_t;

  vec_t vecs [8];
  int   exp_cnt;
  int   waits;
  bit   seen_valid;

  initial begin
    vecs[0] = '{3'd0, 5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 32'h1234_5678};
    vecs[1] = '{3'd7, 5'd9,  1'b1, 1'b0, 1'b1, 1'b1, 32'h1234_5678};
    vecs[2] = '{3'd6, 5'd3,  1'b1, 1'b0, 1'b1, 1'b1, 32'h1234_5678};
    vecs[3] = '{3'd0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h1234_5678};
    vecs[4] = '{3'd2, 5'd4,  1'b0, 1'b0, 1'b1, 1'b0, 32'h2222_2222};
    vecs[5] = '{3'd1, 5'd6,  1'b1, 1'b0, 1'b1, 1'b1, 32'h1111_1111};
    vecs[6] = '{3'd3, 5'd8,  1'b1, 1'b1, 1'b0, 1'b0, 32'h1111_1111};
    vecs[7] = '{3'd5, 5'd31, 1'b1, 1'b0, 1'b1, 1'b1, 32'h5555_5555};

    rst = 1'b1; alu_src = 1'b0; rs2 = 32'hAAAA_0001; imm = 32'h0000_0BB1;
    idle_inputs();
    src[0] = 32'h1234_5678;
    for (int k = 1; k < NUM_SRC; k++) src[k] = 32'h1111_1111 * k;
    m_pending = 1'b0; m_waited = 0; m_rd = '0; m_wr = 1'b0;
    e_rd = '0; e_data = '0; e_cnt = '0;
    tick(); tick();
    chk("reset_cnt", retire_cnt, 32'd0);
    chk("reset_valid", 32'(wb_valid), 32'd0);
    rst = 1'b0;

    // Single-cycle accepts, back to back, with load data already valid.
    exp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1; lu_valid = 1'b1;
      sel = vecs[i].sel; rd = vecs[i].rd; wr_en = vecs[i].wr; flush = vecs[i].flush;
      tick();
      if (vecs[i].x_valid) exp_cnt++;
      chk("vec_valid", 32'(wb_valid), 32'(vecs[i].x_valid));
      chk("vec_wr_en", 32'(wb_wr), 32'(vecs[i].x_wr));
      chk("vec_data", wb_data, vecs[i].x_data);
      chk("vec_cnt", retire_cnt, 32'(exp_cnt));
    end
    idle_inputs(); tick();

    // Load waits for data; valid_in is ignored while waiting.
    valid = 1'b1; sel = 3'(LU_SEL); rd = 5'd7; wr_en = 1'b1; tick();
    sel = 3'd0; rd = 5'd2;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("wait_ready", 32'(ready), 32'd0);
      chk("wait_valid", 32'(wb_valid), 32'd0);
    end
    valid = 1'b0; src[LU_SEL] = 32'hDEAD_BEEF; lu_valid = 1'b1; tick();
    chk("ld_valid", 32'(wb_valid), 32'd1);
    chk("ld_rd", 32'(wb_rd), 32'd7);
    chk("ld_data", wb_data, 32'hDEAD_BEEF);
    idle_inputs(); tick();

    // Load timeout after exactly MAX_WAIT waiting cycles.
    valid = 1'b1; sel = 3'(LU_SEL); rd = 5'd9; wr_en = 1'b1; tick();
    idle_inputs();
    waits = 0; seen_valid = 1'b0;
    while (waits < 40 && !timeout) begin
      tick();
      waits++;
      if (wb_valid) seen_valid = 1'b1;
    end
    chk("timeout_cycles", 32'(waits), 32'(MAX_WAIT));
    chk("timeout_no_valid", 32'(seen_valid), 32'd0);
    chk("timeout_ready", 32'(ready), 32'd1);
    tick();
    chk("timeout_pulse", 32'(timeout), 32'd0);

    // Flush and load data together: flush wins.
    exp_cnt = int'(retire_cnt);
    valid = 1'b1; sel = 3'(LU_SEL); rd = 5'd10; wr_en = 1'b1; tick();
    idle_inputs(); tick();
    flush = 1'b1; lu_valid = 1'b1; tick();
    chk("flush_valid", 32'(wb_valid), 32'd0);
    chk("flush_cnt", retire_cnt, 32'(exp_cnt));
    chk("flush_ready", 32'(ready), 32'd1);
    idle_inputs(); tick();

    // Reset in the middle of a load wait.
    valid = 1'b1; sel = 3'(LU_SEL); rd = 5'd11; wr_en = 1'b1; tick();
    idle_inputs(); tick();
    rst = 1'b1; tick(); tick();
    chk("rst_cnt", retire_cnt, 32'd0);
    chk("rst_data", wb_data, 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    rst = 1'b0;
    src[2] = 32'h0000_0ABC; valid = 1'b1; sel = 3'd2; rd = 5'd12; wr_en = 1'b1; tick();
    chk("post_rst_data", wb_data, 32'h0000_0ABC);
    chk("post_rst_cnt", retire_cnt, 32'd1);
    idle_inputs();
    alu_src = 1'b1; #1; chk("alu_rs2", alu_out, rs2);
    alu_src = 1'b0; #1; chk("alu_imm", alu_out, imm);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(99) == 0);
      valid    = ($urandom_range(9) < 7);
      sel      = SEL_W'($urandom_range(7));
      rd       = 5'($urandom);
      wr_en    = 1'($urandom);
      lu_valid = ($urandom_range(9) < 3);
      flush    = ($urandom_range(19) == 0);
      alu_src  = 1'($urandom);
      rs2      = $urandom;
      imm      = $urandom;
      for (int k = 0; k < NUM_SRC; k++) src[k] = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
